// File: rtl/popcount_seq.sv
// popcount_seq: sequential population count of a W-bit word.
// A single C-bit counter is time-shared over NCH = ceil(W/C) chunks. The
// result appears NCH cycles after the word is accepted and is held until
// the consumer accepts it.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   in_data is valid
//   in_ready   block can accept a word (IDLE)
//   in_data    W-bit word to count
//   out_valid  out_count is valid (DONE)
//   out_ready  consumer accepts out_count
//   out_count  number of set bits in the accepted word, K bits
//   busy       high while a word is being counted or held
module popcount_seq #(
    parameter int W = 64,
    parameter int C = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(W+1)-1:0] out_count,
    output logic                   busy
);

    localparam int NCH = (W + C - 1) / C;
    localparam int K   = $clog2(W + 1);
    localparam int PW  = NCH * C;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  word;
    logic [K-1:0]  acc;
    logic [IW-1:0] idx;
    logic [PW-1:0] padded;
    logic [C-1:0]  chunk;
    logic [K-1:0]  cnt;
    logic          last_chunk;

    // Upper padding bits stay zero so a partial last chunk counts only real bits.
    always_comb begin
        padded         = '0;
        padded[W-1:0]  = word;
    end

    assign chunk      = padded[idx*C +: C];
    assign last_chunk = (idx == IW'(NCH - 1));

    // The one shared C-bit counter.
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < C; i++) begin
            cnt = cnt + K'(chunk[i]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)   state_next = RUN;
            RUN:  if (last_chunk) state_next = DONE;
            DONE: if (out_ready)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            acc  <= '0;
            idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word <= in_data;
                        acc  <= '0;
                        idx  <= '0;
                    end
                end
                RUN: begin
                    acc <= acc + cnt;
                    if (!last_chunk) begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_count = acc;

endmodule
